// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store front-end: funct3 codes, FSM states
// and request legality checks.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_RMW_RD,
    S_RMW_WR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISALIGN,
    ERR_FUNCT3
  } err_t;

  // Illegal funct3 is reported ahead of alignment, since alignment is only
  // meaningful for a known access size.
  function automatic err_t req_check(input logic write, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic bad_f3;
    bad_f3 = write ? (funct3 >= 3'd3)
                   : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
    if (bad_f3)
      return ERR_FUNCT3;
    else if ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0])
      return ERR_MISALIGN;
    else if (funct3 == F3_W && addr_lo != 2'b00)
      return ERR_MISALIGN;
    else
      return ERR_NONE;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/halfword out of a memory word and extends it
// according to the load funct3.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_W:    data = word;
      F3_BU:   data = {24'd0, byte_v};
      F3_HU:   data = {16'd0, half_v};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store front-end for a word-only data memory; sub-word stores
// are done as read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_dout
);

  state_t            state_q, state_d;
  logic              write_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       merged;
  logic [31:0]       load_data;
  logic              accept;
  err_t              req_err_kind;
  logic              resp_valid_d;
  logic              resp_err_d;
  logic [31:0]       resp_rdata_d;

  assign req_ready    = (state_q == S_IDLE);
  assign accept       = req_valid && req_ready;
  assign req_err_kind = req_check(req_write, req_funct3, req_addr[1:0]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && req_err_kind == ERR_NONE) begin
          if (!req_write)                state_d = S_LOAD;
          else if (req_funct3 == F3_W)   state_d = S_STORE;
          else                           state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_IDLE;
      S_STORE:  state_d = S_IDLE;
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  load_align u_load_align (
    .word   (mem_dout),
    .lane   (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (load_data)
  );

  always_comb begin
    merged = merge_q;
    if (f3_q == F3_B)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else if (addr_q[1])
      merged[31:16] = wdata_q[15:0];
    else
      merged[15:0] = wdata_q[15:0];
  end

  // Strobes are gated by reset directly so nothing reaches memory while the
  // state register is still being cleared.
  always_comb begin
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_din   = 32'd0;
    if (state_q != S_IDLE)
      mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    if (!reset) begin
      mem_read  = (state_q == S_LOAD) || (state_q == S_RMW_RD);
      mem_write = write_q && ((state_q == S_STORE) || (state_q == S_RMW_WR));
      if (mem_write)
        mem_din = (state_q == S_STORE) ? wdata_q : merged;
    end
  end

  always_comb begin
    resp_valid_d = (state_q == S_LOAD) || (state_q == S_STORE) || (state_q == S_RMW_WR)
                   || (accept && req_err_kind != ERR_NONE);
    resp_err_d   = accept && (req_err_kind != ERR_NONE);
    resp_rdata_d = (state_q == S_LOAD) ? load_data : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      merge_q    <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state_q    <= state_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      if (accept) begin
        write_q <= req_write;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == S_RMW_RD)
        merge_q <= mem_dout;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: cycle-level strobe checks in the stimulus
// thread, response data checked by a scoreboard monitor against a word memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  resp_t exp_q[$];

  logic [31:0] mem [0:15];
  logic        tb_we = 1'b0;
  logic [3:0]  tb_widx = 4'd0;
  logic [31:0] tb_wdata = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout)
  );

  assign mem_dout = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_write)
      mem[mem_addr[5:2]] <= mem_din;
    else if (tb_we)
      mem[tb_widx] <= tb_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    checks++;
    if (mem_read && mem_write) begin
      errors++;
      $display("FAIL strobe_overlap: read=%0b write=%0b both high", mem_read, mem_write);
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: rdata=0x%08h err=%0b with no request outstanding",
                 resp_rdata, resp_err);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
      end
    end
  end

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    tb_widx  = idx;
    tb_wdata = val;
    tb_we    = 1'b1;
    @(posedge clk);
    #1 tb_we = 1'b0;
    @(negedge clk);
  endtask

  // Starts at a negedge, ends at the negedge of the response cycle, so
  // consecutive calls are back-to-back.
  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input logic [31:0] exp_din, input int n_acc);
    logic rmw;
    rmw = w && (f3 != 3'd2);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    exp_q.push_back('{rdata: exp_rd, err: exp_err});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_funct3 = 3'd7;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'hFFFF_FFFF;
    for (int k = 1; k <= n_acc; k++) begin
      @(negedge clk);
      check("acc_mem_read",  {31'd0, mem_read},  {31'd0, (!w) || (rmw && k == 1)});
      check("acc_mem_write", {31'd0, mem_write}, {31'd0, w && (!rmw || k == 2)});
      check("acc_mem_addr", mem_addr, {addr[31:2], 2'b00});
      check("acc_req_ready", {31'd0, req_ready}, 32'd0);
      if (mem_write) check("acc_mem_din", mem_din, exp_din);
      check("acc_resp_valid", {31'd0, resp_valid}, 32'd0);
    end
    @(negedge clk);
    check("resp_cycle_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_cycle_read",  {31'd0, mem_read},  32'd0);
    check("resp_cycle_write", {31'd0, mem_write}, 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err",   {31'd0, resp_err},   32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_read",   {31'd0, mem_read},  32'd0);
    check("rst_mem_write",  {31'd0, mem_write}, 32'd0);
    check("rst_mem_addr",   mem_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", {31'd0, req_ready}, 32'd1);

    poke(4'd4, 32'h8899_AABB);
    // Loads
    run_req(1'b0, 3'd2, 32'h10, 32'd0, 32'h8899_AABB, 1'b0, 32'd0, 1);
    run_req(1'b0, 3'd0, 32'h13, 32'd0, 32'hFFFF_FF88, 1'b0, 32'd0, 1);
    run_req(1'b0, 3'd4, 32'h13, 32'd0, 32'h0000_0088, 1'b0, 32'd0, 1);
    run_req(1'b0, 3'd1, 32'h12, 32'd0, 32'hFFFF_8899, 1'b0, 32'd0, 1);
    run_req(1'b0, 3'd5, 32'h10, 32'd0, 32'h0000_AABB, 1'b0, 32'd0, 1);
    run_req(1'b0, 3'd0, 32'h11, 32'd0, 32'hFFFF_FFAA, 1'b0, 32'd0, 1);
    run_req(1'b0, 3'd4, 32'h12, 32'd0, 32'h0000_0099, 1'b0, 32'd0, 1);

    // SB / SH read-modify-write
    run_req(1'b1, 3'd0, 32'h11, 32'hFFFF_FF5A, 32'd0, 1'b0, 32'h8899_5ABB, 2);
    check("mem_after_sb", mem[4], 32'h8899_5ABB);
    poke(4'd4, 32'h8899_AABB);
    run_req(1'b1, 3'd1, 32'h12, 32'hABCD_1234, 32'd0, 1'b0, 32'h1234_AABB, 2);
    check("mem_after_sh", mem[4], 32'h1234_AABB);

    // Errors: no strobes, response in cycle 1
    run_req(1'b0, 3'd2, 32'h12, 32'd0, 32'd0, 1'b1, 32'd0, 0);
    run_req(1'b1, 3'd1, 32'h11, 32'h5555, 32'd0, 1'b1, 32'd0, 0);
    run_req(1'b0, 3'd3, 32'h10, 32'd0, 32'd0, 1'b1, 32'd0, 0);
    run_req(1'b1, 3'd3, 32'h10, 32'd0, 32'd0, 1'b1, 32'd0, 0);
    check("mem_after_err", mem[4], 32'h1234_AABB);

    // Reset during RMW_RD of an SB drops the operation
    poke(4'd5, 32'hCAFE_F00D);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'h14;
    req_wdata  = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_read", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_gate_read",  {31'd0, mem_read},  32'd0);
    check("rst_gate_write", {31'd0, mem_write}, 32'd0);
    check("rst_gate_din",   mem_din, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("post_rst_write", {31'd0, mem_write}, 32'd0);
      check("post_rst_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    check("mem_after_rst", mem[5], 32'hCAFE_F00D);

    // Back-to-back SW then LW
    run_req(1'b1, 3'd2, 32'h18, 32'hDEAD_BEEF, 32'd0, 1'b0, 32'hDEAD_BEEF, 1);
    run_req(1'b0, 3'd2, 32'h18, 32'd0, 32'hDEAD_BEEF, 1'b0, 32'd0, 1);
    check("mem_after_sw", mem[6], 32'hDEAD_BEEF);

    repeat (3) @(negedge clk);
    check("pending_resp_count", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
